// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes and FSM states shared by the sequential ALU
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NEZ = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

endpackage

// File: rtl/alu_mult_serie.sv
// rtl/alu_mult_serie.sv - fixed-latency shift-add multiplier, WIDTH iterations per product
module alu_mult_serie #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] producto
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW:0]     counter;

  // producto is the accumulator after the current iteration, so the owner
  // can register it on the same edge that done is high.
  assign producto = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (counter == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      busy    <= 1'b0;
      counter <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      counter <= '0;
      acc     <= '0;
      mcand   <= A;
      mplier  <= B;
    end else if (busy) begin
      acc     <= producto;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      counter <= counter + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - registered ALU with valid/ready input and serial multiply
module alu_secuencial
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       aluOP,
  output logic             valid_out,
  output logic [WIDTH-1:0] resultadoALU,
  output logic             zero,
  output logic             carry
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             shift_big;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign sum       = {1'b0, A} + {1'b0, B};
  assign shift_big = |B[WIDTH-1:SHW];
  assign accept    = valid_in && ready;
  assign mul_start = accept && (aluOP == OP_MUL) && !mul_busy;

  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    case (aluOP)
      OP_ADD: begin
        res_c   = sum[WIDTH-1:0];
        carry_c = sum[WIDTH];
      end
      OP_SUB: begin
        res_c   = A - B;
        carry_c = (A < B);
      end
      OP_AND: res_c = A & B;
      OP_OR:  res_c = A | B;
      OP_NEZ: res_c = {{(WIDTH-1){1'b0}}, |B};
      OP_SHL: res_c = shift_big ? '0 : (A << B[SHW-1:0]);
      OP_SHR: res_c = shift_big ? '0 : (A >> B[SHW-1:0]);
      default: res_c = '0;
    endcase
  end

  alu_mult_serie #(.WIDTH(WIDTH)) u_mult (
    .clk      (clk),
    .reset    (reset),
    .start    (mul_start),
    .A        (A),
    .B        (B),
    .busy     (mul_busy),
    .done     (mul_done),
    .producto (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      ready        <= 1'b1;
      valid_out    <= 1'b0;
      resultadoALU <= '0;
      zero         <= 1'b1;
      carry        <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (mul_start) begin
            state <= MUL;
            ready <= 1'b0;
          end else if (accept) begin
            resultadoALU <= res_c;
            zero         <= (res_c == '0);
            carry        <= carry_c;
            valid_out    <= 1'b1;
          end
        end
        MUL: begin
          if (mul_done) begin
            resultadoALU <= mul_prod;
            zero         <= (mul_prod == '0);
            carry        <= 1'b0;
            valid_out    <= 1'b1;
            ready        <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_secuencial.sv
// tb/tb_alu_secuencial.sv - directed vector bench for alu_secuencial at WIDTH=64
module tb_alu_secuencial;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        ready;
  logic [63:0] A;
  logic [63:0] B;
  logic [2:0]  aluOP;
  logic        valid_out;
  logic [63:0] resultadoALU;
  logic        zero;
  logic        carry;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t tbl[12];

  alu_secuencial #(.WIDTH(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready        (ready),
    .A            (A),
    .B            (B),
    .aluOP        (aluOP),
    .valid_out    (valid_out),
    .resultadoALU (resultadoALU),
    .zero         (zero),
    .carry        (carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ready"},     64'(ready), 64'd1);
    chk({tag, " valid_out"}, 64'(valid_out), 64'd0);
    chk({tag, " result"},    resultadoALU, 64'd0);
    chk({tag, " zero"},      64'(zero), 64'd1);
    chk({tag, " carry"},     64'(carry), 64'd0);
  endtask

  // Issue a multiply, then watch ready/valid_out until the result appears.
  task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input logic exp_z);
    int lat;
    bit ready_hi;
    valid_in = 1'b1; aluOP = 3'b111; A = a; B = b;
    tick();
    valid_in = 1'b0;
    lat = -1;
    ready_hi = 1'b0;
    for (int n = 0; n < 100 && lat < 0; n++) begin
      if (n > 0) tick();
      if (valid_out) lat = n;
      else if (ready) ready_hi = 1'b1;
    end
    chk({tag, " latency"}, 64'(lat), 64'd64);
    chk({tag, " ready low while busy"}, 64'(ready_hi), 64'd0);
    chk({tag, " result"}, resultadoALU, exp);
    chk({tag, " zero"}, 64'(zero), 64'(exp_z));
    chk({tag, " carry"}, 64'(carry), 64'd0);
    chk({tag, " ready back"}, 64'(ready), 64'd1);
  endtask

  initial begin
    int lat;
    int pulses;
    bit early;

    tbl[0]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b1};
    tbl[1]  = '{3'b001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};
    tbl[2]  = '{3'b011, 64'hF0, 64'h0F, 64'hFF, 1'b0, 1'b0};
    tbl[3]  = '{3'b101, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 1'b0, 1'b0};
    tbl[4]  = '{3'b101, 64'd1, 64'd64, 64'd0, 1'b1, 1'b0};
    tbl[5]  = '{3'b110, 64'h8000_0000_0000_0000, 64'd200, 64'd0, 1'b1, 1'b0};
    tbl[6]  = '{3'b100, 64'd99, 64'd7, 64'd1, 1'b0, 1'b0};
    tbl[7]  = '{3'b100, 64'd99, 64'd0, 64'd0, 1'b1, 1'b0};
    tbl[8]  = '{3'b010, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0};
    tbl[9]  = '{3'b000, 64'd5, 64'd7, 64'd12, 1'b0, 1'b0};
    tbl[10] = '{3'b001, 64'd5, 64'd5, 64'd0, 1'b1, 1'b0};
    tbl[11] = '{3'b110, 64'hF0, 64'd4, 64'hF, 1'b0, 1'b0};

    reset = 1'b1; valid_in = 1'b0; A = '0; B = '0; aluOP = 3'b000;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk_reset_state("reset");

    // Back-to-back simple ops, one per cycle.
    for (int i = 0; i < 12; i++) begin
      valid_in = 1'b1; aluOP = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
      tick();
      chk($sformatf("vec%0d valid_out", i), 64'(valid_out), 64'd1);
      chk($sformatf("vec%0d result", i), resultadoALU, tbl[i].res);
      chk($sformatf("vec%0d zero", i), 64'(zero), 64'(tbl[i].z));
      chk($sformatf("vec%0d carry", i), 64'(carry), 64'(tbl[i].c));
      chk($sformatf("vec%0d ready", i), 64'(ready), 64'd1);
    end
    valid_in = 1'b0;
    tick();
    chk("idle valid_out drops", 64'(valid_out), 64'd0);
    chk("idle result held", resultadoALU, 64'hF);

    run_mul("mul 12345*678", 64'd12345, 64'd678, 64'd8369910, 1'b0);
    tick();
    chk("mul pulse single", 64'(valid_out), 64'd0);
    run_mul("mul trunc", 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b1);

    // Stall: ADD 1+1 held on the input throughout a multiply.
    valid_in = 1'b1; aluOP = 3'b111; A = 64'd3; B = 64'd4;
    tick();
    aluOP = 3'b000; A = 64'd1; B = 64'd1;
    lat = -1;
    for (int n = 0; n < 100 && lat < 0; n++) begin
      if (n > 0) tick();
      if (valid_out) lat = n;
    end
    chk("stall mul latency", 64'(lat), 64'd64);
    chk("stall mul result", resultadoALU, 64'd12);
    tick();
    valid_in = 1'b0;
    chk("stall add valid_out", 64'(valid_out), 64'd1);
    chk("stall add result", resultadoALU, 64'd2);
    chk("stall add zero", 64'(zero), 64'd0);

    // Reset at cycle 20 of a multiply aborts it silently.
    valid_in = 1'b1; aluOP = 3'b111; A = 64'd12345; B = 64'd678;
    tick();
    valid_in = 1'b0;
    early = 1'b0;
    for (int n = 1; n < 20; n++) begin
      tick();
      if (valid_out) early = 1'b1;
    end
    chk("abort no early pulse", 64'(early), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_reset_state("abort");
    pulses = 0;
    for (int n = 0; n < 80; n++) begin
      tick();
      if (valid_out) pulses++;
    end
    chk("abort no valid_out", 64'(pulses), 64'd0);
    chk("abort ready", 64'(ready), 64'd1);
    valid_in = 1'b1; aluOP = 3'b000; A = 64'd2; B = 64'd2;
    tick();
    valid_in = 1'b0;
    chk("post-abort add valid_out", 64'(valid_out), 64'd1);
    chk("post-abort add result", resultadoALU, 64'd4);
    chk("post-abort add carry", 64'(carry), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
